knn_insert_sort: RTL and testbench

- Consumer of the distance datapath. Accepts a stream of (squared distance, label) pairs for one test point.
- Keeps the K smallest distances in ascending order in a register-based insertion list, one insert per cycle.
- After the stream ends, the sorted neighbours are read back through an indexed, registered read port for classification by software or a vote unit.

---
 rtl/knn_insert_sort.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_knn_insert_sort.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_insert_sort.sv
// knn_insert_sort
//   Keeps the K smallest (distance, label) pairs of one test point in an
//   ascending, register-based insertion list. One sample per cycle is
//   inserted; after the final sample the list is read back through an
//   indexed, registered read port.
//
// Optional build macro: KNN_IDX_EN
//   When defined, each entry also stores a 16-bit accepted-sample index
//   (counter value at insertion), returned on rd_idx with rd_dist timing.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     one-cycle pulse: clear the list and begin a new test point
//   in_valid  sample valid
//   in_ready  block can accept a sample (FILL state and no start)
//   in_last   final sample of the stream (qualified by in_valid&&in_ready)
//   dist_in   unsigned squared distance
//   label_in  sample label
//   done      list final, readout allowed
//   count     number of occupied entries (saturates at K)
//   rd_en     read request (honoured only while done=1)
//   rd_addr   entry index, 0 = nearest
//   rd_valid  one-cycle read data valid pulse
//   rd_dist   distance of the entry read (0 if rd_addr >= count)
//   rd_label  label of the entry read (0 if rd_addr >= count)
//   rd_idx    (KNN_IDX_EN only) insertion index of the entry read

module knn_insert_sort #(
  parameter int W     = 32,
  parameter int K     = 4,
  parameter int LBL_W = 8,
  localparam int CW   = $clog2(K + 1),
  localparam int AW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [W-1:0]     dist_in,
  input  logic [LBL_W-1:0] label_in,
  output logic             done,
  output logic [CW-1:0]    count,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic [W-1:0]     rd_dist,
  output logic [LBL_W-1:0] rd_label
`ifdef KNN_IDX_EN
  ,
  output logic [15:0]      rd_idx
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               done_q;

  // Entry storage; occupied flags mark valid entries, so all-ones is a legal distance.
  logic [W-1:0]       dist_q   [K];
  logic [W-1:0]       dist_d   [K];
  logic [LBL_W-1:0]   label_q  [K];
  logic [LBL_W-1:0]   label_d  [K];
  logic [K-1:0]       occ_q;
  logic [K-1:0]       occ_d;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;

  // Entry i-1 as seen by entry i (entry 0 has no predecessor).
  logic [W-1:0]       prev_dist_s  [K];
  logic [LBL_W-1:0]   prev_label_s [K];
  logic [K-1:0]       prev_occ_s;

  logic [CW-1:0]      pos_s;
  logic               accept_s;
  logic               insert_s;

  logic               rd_valid_q;
  logic [W-1:0]       rd_dist_q;
  logic [LBL_W-1:0]   rd_label_q;
  logic [W-1:0]       rd_dist_s;
  logic [LBL_W-1:0]   rd_label_s;

`ifdef KNN_IDX_EN
  logic [15:0]        ctr_q;
  logic [15:0]        ctr_d;
  logic [15:0]        idx_q      [K];
  logic [15:0]        idx_d      [K];
  logic [15:0]        prev_idx_s [K];
  logic [15:0]        rd_idx_q;
  logic [15:0]        rd_idx_s;
`endif

  // start wins over a coincident sample, so it gates in_ready combinationally.
  assign in_ready = (state_q == ST_FILL) && !start;
  assign accept_s = in_valid && in_ready;
  assign done     = done_q;
  assign count    = count_q;
  assign rd_valid = rd_valid_q;
  assign rd_dist  = rd_dist_q;
  assign rd_label = rd_label_q;
`ifdef KNN_IDX_EN
  assign rd_idx   = rd_idx_q;
`endif

  // Insert position: occupied entries with dist <= dist_in (newer ties go after older ones).
  always_comb begin
    pos_s = '0;
    for (int i = 0; i < K; i++) begin
      if (occ_q[i] && (dist_q[i] <= dist_in)) begin
        pos_s = pos_s + CW'(1);
      end else begin
        pos_s = pos_s;
      end
    end
  end

  // A sample that is not smaller than every entry of a full list is consumed without effect.
  assign insert_s = accept_s && (pos_s < CW'(K));

  // Predecessor view used by the shift path.
  always_comb begin
    prev_dist_s[0]  = '0;
    prev_label_s[0] = '0;
    prev_occ_s[0]   = 1'b0;
`ifdef KNN_IDX_EN
    prev_idx_s[0]   = '0;
`endif
    for (int i = 1; i < K; i++) begin
      prev_dist_s[i]  = dist_q[i-1];
      prev_label_s[i] = label_q[i-1];
      prev_occ_s[i]   = occ_q[i-1];
`ifdef KNN_IDX_EN
      prev_idx_s[i]   = idx_q[i-1];
`endif
    end
  end

  // List next state: hold, clear on start, or write at pos_s and shift the tail down by one.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      dist_d[i]  = dist_q[i];
      label_d[i] = label_q[i];
      occ_d[i]   = occ_q[i];
`ifdef KNN_IDX_EN
      idx_d[i]   = idx_q[i];
`endif
    end
    if (start) begin
      occ_d = '0;
    end else if (insert_s) begin
      for (int i = 0; i < K; i++) begin
        if (CW'(i) == pos_s) begin
          dist_d[i]  = dist_in;
          label_d[i] = label_in;
          occ_d[i]   = 1'b1;
`ifdef KNN_IDX_EN
          idx_d[i]   = ctr_q;
`endif
        end else if (CW'(i) > pos_s) begin
          dist_d[i]  = prev_dist_s[i];
          label_d[i] = prev_label_s[i];
          occ_d[i]   = prev_occ_s[i];
`ifdef KNN_IDX_EN
          idx_d[i]   = prev_idx_s[i];
`endif
        end else begin
          occ_d[i]   = occ_q[i];
        end
      end
    end else begin
      occ_d = occ_q;
    end
  end

  // Occupancy count: cleared by start, +1 per accepted sample, saturating at K.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (accept_s && (count_q < CW'(K))) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

`ifdef KNN_IDX_EN
  // Accepted-sample counter: cleared by start, wraps naturally at 16 bits.
  always_comb begin
    ctr_d = ctr_q;
    if (start) begin
      ctr_d = 16'd0;
    end else if (accept_s) begin
      ctr_d = ctr_q + 16'd1;
    end else begin
      ctr_d = ctr_q;
    end
  end
`endif

  // Read mux: addresses at or beyond count return zero data.
  always_comb begin
    rd_dist_s  = '0;
    rd_label_s = '0;
`ifdef KNN_IDX_EN
    rd_idx_s   = '0;
`endif
    for (int i = 0; i < K; i++) begin
      if ((AW'(i) == rd_addr) && (CW'(i) < count_q)) begin
        rd_dist_s  = dist_q[i];
        rd_label_s = label_q[i];
`ifdef KNN_IDX_EN
        rd_idx_s   = idx_q[i];
`endif
      end else begin
        rd_dist_s  = rd_dist_s;
      end
    end
  end

  // Control FSM with registered done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= ST_FILL;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        ST_FILL: begin
          if (accept_s && in_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FILL;
            done_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // List storage and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= '0;
        label_q[i] <= '0;
`ifdef KNN_IDX_EN
        idx_q[i]   <= '0;
`endif
      end
      occ_q   <= '0;
      count_q <= '0;
`ifdef KNN_IDX_EN
      ctr_q   <= '0;
`endif
    end else begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= dist_d[i];
        label_q[i] <= label_d[i];
`ifdef KNN_IDX_EN
        idx_q[i]   <= idx_d[i];
`endif
      end
      occ_q   <= occ_d;
      count_q <= count_d;
`ifdef KNN_IDX_EN
      ctr_q   <= ctr_d;
`endif
    end
  end

  // Registered read port: one-cycle valid pulse, data held until the next honoured read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_dist_q  <= '0;
      rd_label_q <= '0;
`ifdef KNN_IDX_EN
      rd_idx_q   <= '0;
`endif
    end else if (rd_en && done_q) begin
      rd_valid_q <= 1'b1;
      rd_dist_q  <= rd_dist_s;
      rd_label_q <= rd_label_s;
`ifdef KNN_IDX_EN
      rd_idx_q   <= rd_idx_s;
`endif
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_knn_insert_sort.sv
// Self-checking bench for knn_insert_sort (K=4, W=32, LBL_W=8): directed
// scenarios plus randomized streams compared against a queue-based model.
module tb_knn_insert_sort;

  localparam int W     = 32;
  localparam int K     = 4;
  localparam int LBL_W = 8;
  localparam int CW    = $clog2(K + 1);
  localparam int AW    = $clog2(K);

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [W-1:0]     dist_in;
  logic [LBL_W-1:0] label_in;
  logic             done;
  logic [CW-1:0]    count;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [W-1:0]     rd_dist;
  logic [LBL_W-1:0] rd_label;
`ifdef KNN_IDX_EN
  logic [15:0]      rd_idx;
`endif

  knn_insert_sort #(.W(W), .K(K), .LBL_W(LBL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .dist_in  (dist_in),
    .label_in (label_in),
    .done     (done),
    .count    (count),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_dist  (rd_dist),
    .rd_label (rd_label)
`ifdef KNN_IDX_EN
    ,
    .rd_idx   (rd_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sorted queue of the K nearest, plus accept counter.
  typedef struct {
    logic [W-1:0]     d;
    logic [LBL_W-1:0] l;
    logic [15:0]      ix;
  } ent_t;

  ent_t        mq[$];
  int          m_acc;
  logic [15:0] m_ctr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    mq.delete();
    m_acc = 0;
    m_ctr = 16'd0;
  endfunction

  function automatic void m_insert(input logic [W-1:0] d, input logic [LBL_W-1:0] l);
    int   p;
    ent_t e;
    p = 0;
    foreach (mq[i]) if (mq[i].d <= d) p++;
    if (p < K) begin
      e.d  = d;
      e.l  = l;
      e.ix = m_ctr;
      mq.insert(p, e);
      if (mq.size() > K) mq.delete(K);
    end
    m_acc++;
    m_ctr = m_ctr + 16'd1;
  endfunction

  function automatic int m_count();
    return (m_acc > K) ? K : m_acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_clear();
    chk("start_count", 64'(count), 64'd0);
    chk("start_done", 64'(done), 64'd0);
  endtask

  // Present one sample; in_valid stays high afterwards so sends run back to back.
  task automatic send(input logic [W-1:0] d, input logic [LBL_W-1:0] l, input logic last);
    in_valid = 1'b1;
    dist_in  = d;
    label_in = l;
    in_last  = last;
    #1;
    chk("in_ready", 64'(in_ready), 64'd1);
    tick();
    m_insert(d, l);
    chk("count", 64'(count), 64'(m_count()));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_one(input int a);
    logic [W-1:0]     ed;
    logic [LBL_W-1:0] el;
    logic [15:0]      ei;
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en   = 1'b0;
    if (a < mq.size()) begin
      ed = mq[a].d; el = mq[a].l; ei = mq[a].ix;
    end else begin
      ed = '0; el = '0; ei = '0;
    end
    chk("rd_valid", 64'(rd_valid), 64'd1);
    chk("rd_dist", 64'(rd_dist), 64'(ed));
    chk("rd_label", 64'(rd_label), 64'(el));
`ifdef KNN_IDX_EN
    chk("rd_idx", 64'(rd_idx), 64'(ei));
`endif
  endtask

  task automatic read_all();
    for (int a = 0; a < K; a++) read_one(a);
    tick();
    chk("rd_valid_pulse", 64'(rd_valid), 64'd0);
  endtask

  task automatic finish_stream();
    idle();
    chk("done", 64'(done), 64'd1);
    chk("final_count", 64'(count), 64'(m_count()));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    dist_in = '0; label_in = '0; rd_en = 1'b0; rd_addr = '0;
    m_clear();
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_dist", 64'(rd_dist), 64'd0);
    chk("rst_rd_label", 64'(rd_label), 64'd0);
`ifdef KNN_IDX_EN
    chk("rst_rd_idx", 64'(rd_idx), 64'd0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // Six-sample stream with ties and a drop.
    do_start();
    send(32'd10, 8'h0A, 1'b0);
    send(32'd3,  8'h0B, 1'b0);
    send(32'd7,  8'h0C, 1'b0);
    send(32'd3,  8'h0D, 1'b0);
    send(32'd20, 8'h0E, 1'b0);
    send(32'd1,  8'h0F, 1'b1);
    finish_stream();
    chk("dir_count4", 64'(count), 64'd4);
    read_all();

    // Short stream and out-of-range read.
    do_start();
    send(32'd5, 8'h0A, 1'b0);
    send(32'd2, 8'h0B, 1'b1);
    finish_stream();
    chk("dir_count2", 64'(count), 64'd2);
    read_one(0);
    read_one(1);
    read_one(3);
    chk("oob_dist", 64'(rd_dist), 64'd0);

    // Full list, then ties with the maximum and the all-ones distance.
    do_start();
    send(32'd1, 8'h11, 1'b0);
    send(32'd2, 8'h12, 1'b0);
    send(32'd3, 8'h13, 1'b0);
    send(32'd4, 8'h14, 1'b0);
    send(32'd4, 8'h15, 1'b0);
    send(32'hFFFF_FFFF, 8'h16, 1'b1);
    finish_stream();
    read_all();

    // start coincident with in_valid while done: sample dropped.
    in_valid = 1'b1; dist_in = 32'd9; label_in = 8'h99; in_last = 1'b1;
    start = 1'b1;
    #1;
    chk("start_blocks_ready", 64'(in_ready), 64'd0);
    tick();
    start = 1'b0;
    idle();
    m_clear();
    #1;
    chk("restart_count", 64'(count), 64'd0);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_fill_ready", 64'(in_ready), 64'd1);
    send(32'd50, 8'h50, 1'b1);
    finish_stream();
    read_all();

    // Randomized test points.
    for (int t = 0; t < 25; t++) begin
      int n;
      do_start();
      n = $urandom_range(1, 12);
      for (int s = 0; s < n; s++) begin
        logic [W-1:0] d;
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      d = W'($urandom_range(0, 15));
        else if (r < 8) d = W'($urandom);
        else            d = 32'hFFFF_FFFF;
        send(d, LBL_W'($urandom_range(0, 255)), (s == n - 1));
        if ((s != n - 1) && ($urandom_range(0, 3) == 0)) begin
          idle();
          rd_en = 1'b1;
          rd_addr = '0;
          tick();
          rd_en = 1'b0;
          chk("rd_ignored_fill", 64'(rd_valid), 64'd0);
        end
      end
      finish_stream();
      read_all();
    end

    // Reset in the middle of a stream.
    do_start();
    send(32'd8, 8'h01, 1'b0);
    send(32'd6, 8'h02, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    m_clear();
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd0);
    rd_en = 1'b1;
    rd_addr = '0;
    tick();
    rd_en = 1'b0;
    chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
